// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write port, clear request, packed read ports and status.
// The master drives the requests and the slave (the register file) drives the results.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 3
);
    logic                    i_clr;
    logic                    i_wen;
    logic [ADDR_W-1:0]       i_wreg;
    logic [DATA_W-1:0]       i_wdata;
    logic [NREAD*ADDR_W-1:0] i_raddr;
    logic [NREAD*DATA_W-1:0] o_rdata;
    logic                    o_busy;
    logic                    o_wdrop;

    modport master (
        output i_clr, i_wen, i_wreg, i_wdata, i_raddr,
        input  o_rdata, o_busy, o_wdrop
    );

    modport slave (
        input  i_clr, i_wen, i_wreg, i_wdata, i_raddr,
        output o_rdata, o_busy, o_wdrop
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file. r0 is hardwired to zero, and the array is cleared by a one-entry-per-cycle sweep.
// Defining REGFILE_BYPASS_EN compiles in same-cycle write-to-read forwarding while the file is in IDLE.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 3
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              wdrop;
    logic              wr_nonzero;
    logic [DATA_W-1:0] mem [DEPTH];

    assign wr_nonzero = bus.i_wen && (bus.i_wreg != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            ptr   <= '0;
            wdrop <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    ptr   <= ptr + 1'b1;
                    wdrop <= wr_nonzero;
                    if (ptr == ADDR_W'(DEPTH - 1)) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    wdrop <= 1'b0;
                    if (bus.i_clr) begin
                        state <= ST_CLEAR;
                        ptr   <= '0;
                    end
                end
            endcase
        end
    end

    // The array has no reset of its own so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_CLEAR) begin
                mem[ptr] <= '0;
            end else if (wr_nonzero) begin
                mem[bus.i_wreg] <= bus.i_wdata;
            end
        end
    end

    assign bus.o_busy  = (state == ST_CLEAR);
    assign bus.o_wdrop = wdrop;

    logic [NREAD*DATA_W-1:0] rdata;

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NREAD; k++) begin
            logic [ADDR_W-1:0] addr;
            addr = bus.i_raddr[k*ADDR_W +: ADDR_W];
            if ((state == ST_IDLE) && (addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
                if (wr_nonzero && (bus.i_wreg == addr)) begin
                    rdata[k*DATA_W +: DATA_W] = bus.i_wdata;
                end else begin
                    rdata[k*DATA_W +: DATA_W] = mem[addr];
                end
`else
                rdata[k*DATA_W +: DATA_W] = mem[addr];
`endif
            end
        end
    end

    assign bus.o_rdata = rdata;
endmodule
